// File: rtl/pfcop_host_seq.sv
// Host-side sequencer for the PFCOP prime-field coprocessor: one 256-bit request in, operands streamed
// over the 16-bit load port, result gathered back. Optional WAIT timeout: define PFSEQ_TIMEOUT_EN.
module pfcop_host_seq #(
   parameter int TMO_W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic         load_p,
   input  logic [255:0] a_in,
   input  logic [255:0] b_in,
   input  logic [255:0] p_in,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [255:0] result,
   output logic         load_en,
   output logic [3:0]   load_addr,
   output logic [15:0]  datain,
   output logic         madd_en,
   output logic         msub_en,
   output logic         mmul_en,
   output logic         minv_mdiv,
   output logic         minv_mdiv_en,
   output logic         out_en,
   output logic [1:0]   out_addr,
   input  logic [15:0]  dataout,
   input  logic         madd_msub_rdy,
   input  logic         mmul_rdy,
   input  logic         minv_mdiv_rdy
);

   typedef enum logic [3:0] {IDLE, LOAD_A, LOAD_B, LOAD_P, GO, BLANK, WAIT, READ, DONE} state_t;

   state_t         state_q, state_d;
   logic [4:0]     cnt_q, cnt_d;
   logic [255:0]   a_q, a_d, b_q, b_d, p_q, p_d;
   logic [2:0]     op_q, op_d;
   logic           loadP_q, loadP_d;
   logic [255:0]   shadow_q, shadow_d;
   logic [255:0]   result_d;
   logic           err_d;
   logic           rdySel;
   logic [3:0]     rdWord;
   logic [255:0]   operand;

`ifdef PFSEQ_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_q, tmoInc;
   logic             tmoExpired;

   assign tmoInc     = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
   assign tmoExpired = (state_q == WAIT) && (&tmoInc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_q <= '0;
      else        tmo_q <= (state_q == WAIT) ? tmoInc : '0;
   end
`else
   logic             tmoExpired;
   logic [TMO_W-1:0] unusedTmo;

   assign tmoExpired = 1'b0;
   assign unusedTmo  = '0;
`endif

   always_comb begin
      case (op_q)
         3'd0, 3'd1: rdySel = madd_msub_rdy;
         3'd2:       rdySel = mmul_rdy;
         default:    rdySel = minv_mdiv_rdy;
      endcase
   end

   assign rdWord = cnt_q[3:0] - 4'd1;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      p_d      = p_q;
      op_d     = op_q;
      loadP_d  = loadP_q;
      shadow_d = shadow_q;
      result_d = result;
      err_d    = err;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a_in;
               b_d     = b_in;
               p_d     = p_in;
               op_d    = op;
               loadP_d = load_p;
               cnt_d   = '0;
               err_d   = (op > 3'd4);
               state_d = (op > 3'd4) ? DONE : LOAD_A;
            end
         end
         LOAD_A, LOAD_B, LOAD_P: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q[3:0] == 4'd15) begin
               cnt_d = '0;
               case (state_q)
                  LOAD_A:  state_d = LOAD_B;
                  LOAD_B:  state_d = loadP_q ? LOAD_P : GO;
                  default: state_d = GO;
               endcase
            end
         end
         GO: begin
            cnt_d   = '0;
            state_d = BLANK;
         end
         // Ready is deliberately ignored here so a flag left over from the previous op cannot end this one.
         BLANK: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd1) begin
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (rdySel) begin
               cnt_d   = '0;
               state_d = READ;
            end else if (tmoExpired) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         // dataout lags out_en by one cycle, so word k lands while the counter reads k+1.
         READ: begin
            if (cnt_q != 5'd0) shadow_d[{rdWord, 4'b0000} +: 16] = dataout;
            if (cnt_q == 5'd16) begin
               result_d = shadow_d;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      operand = '0;
      case (state_d)
         LOAD_A:  operand = a_d;
         LOAD_B:  operand = b_d;
         LOAD_P:  operand = p_d;
         default: operand = '0;
      endcase
   end

   assign out_addr = 2'd0;

   // PFCOP-facing outputs are decoded from the next state so they register in step with the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         p_q          <= '0;
         op_q         <= '0;
         loadP_q      <= 1'b0;
         shadow_q     <= '0;
         result       <= '0;
         err          <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         load_en      <= 1'b0;
         load_addr    <= '0;
         datain       <= '0;
         madd_en      <= 1'b0;
         msub_en      <= 1'b0;
         mmul_en      <= 1'b0;
         minv_mdiv    <= 1'b0;
         minv_mdiv_en <= 1'b0;
         out_en       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         p_q          <= p_d;
         op_q         <= op_d;
         loadP_q      <= loadP_d;
         shadow_q     <= shadow_d;
         result       <= result_d;
         err          <= err_d;
         busy         <= (state_d != IDLE) && (state_d != DONE);
         done         <= (state_d == DONE);
         load_en      <= (state_d == LOAD_A) || (state_d == LOAD_B) || (state_d == LOAD_P);
         load_addr    <= (state_d == LOAD_B) ? 4'd1 : (state_d == LOAD_P) ? 4'd2 : 4'd0;
         datain       <= operand[{cnt_d[3:0], 4'b0000} +: 16];
         madd_en      <= (state_d == GO) && (op_q == 3'd0);
         msub_en      <= (state_d == GO) && (op_q == 3'd1);
         mmul_en      <= (state_d == GO) && (op_q == 3'd2);
         minv_mdiv_en <= (state_d == GO) && ((op_q == 3'd3) || (op_q == 3'd4));
         minv_mdiv    <= ((state_d == GO) || (state_d == BLANK) || (state_d == WAIT)) && (op_q == 3'd4);
         out_en       <= (state_d == READ) && (cnt_d != 5'd16);
      end
   end

endmodule

// File: tb/tb_pfcop_host_seq.sv
// Bench for pfcop_host_seq: a small behavioural PFCOP answers the load/enable/read traffic and a
// scoreboard checks each done against hand-computed results.
module tb_pfcop_host_seq;

   localparam int TMO_W = 4;
`ifdef PFSEQ_TIMEOUT_EN
   localparam int STUCK_DELAY = 12;
`else
   localparam int STUCK_DELAY = 20;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op = '0;
   logic         load_p = 1'b0;
   logic [255:0] a_in = '0, b_in = '0, p_in = '0;
   logic         busy, done, err;
   logic [255:0] result;
   logic         load_en;
   logic [3:0]   load_addr;
   logic [15:0]  datain;
   logic         madd_en, msub_en, mmul_en, minv_mdiv, minv_mdiv_en, out_en;
   logic [1:0]   out_addr;
   logic [15:0]  dataout = '0;
   logic         madd_msub_rdy, mmul_rdy, minv_mdiv_rdy;

   pfcop_host_seq #(.TMO_W(TMO_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .load_p(load_p),
      .a_in(a_in), .b_in(b_in), .p_in(p_in),
      .busy(busy), .done(done), .err(err), .result(result),
      .load_en(load_en), .load_addr(load_addr), .datain(datain),
      .madd_en(madd_en), .msub_en(msub_en), .mmul_en(mmul_en),
      .minv_mdiv(minv_mdiv), .minv_mdiv_en(minv_mdiv_en),
      .out_en(out_en), .out_addr(out_addr),
      .dataout(dataout), .madd_msub_rdy(madd_msub_rdy), .mmul_rdy(mmul_rdy),
      .minv_mdiv_rdy(minv_mdiv_rdy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int startCyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference arithmetic for the PFCOP model, written directly from the modular definitions.
   function automatic logic [255:0] modelInv(input logic [255:0] x, input logic [255:0] m);
      logic [511:0] pr;
      for (int i = 1; i < 256; i++) begin
         pr = {256'b0, x % m} * 512'(i);
         if ((pr % {256'b0, m}) == 512'd1) return 256'(i);
      end
      return '0;
   endfunction

   function automatic logic [255:0] modelCompute(input logic [2:0] o, input logic [255:0] x,
                                                 input logic [255:0] y, input logic [255:0] m);
      logic [256:0] s;
      logic [511:0] pr;
      if (m == '0) return '0;
      case (o)
         3'd0: begin s = {1'b0, x} + {1'b0, y}; return 256'(s % {1'b0, m}); end
         3'd1: begin s = {1'b0, x % m} + {1'b0, m} - {1'b0, y % m}; return 256'(s % {1'b0, m}); end
         3'd2: begin pr = {256'b0, x} * {256'b0, y}; return 256'(pr % {256'b0, m}); end
         3'd3: return modelInv(x, m);
         default: begin pr = {256'b0, x} * {256'b0, modelInv(y, m)}; return 256'(pr % {256'b0, m}); end
      endcase
   endfunction

   logic [255:0] mA = '0, mB = '0, mP = '0, mRes = '0;
   logic         mRdy = 1'b0, mDrop = 1'b0, mFresh = 1'b0;
   logic [1:0]   mGrp = '0;
   int           mCd = 0;
   int           rdyDelay = 3;
   logic         ldActive = 1'b0, outActive = 1'b0;
   logic [3:0]   ldIdx = '0, ldAddrPrev = '0, outIdx = '0;
   logic [3:0]   ldCur, outCur;
   logic         enSeen;
   logic [2:0]   opSeen;

   assign ldCur  = (ldActive && (load_addr == ldAddrPrev)) ? ldIdx + 4'd1 : 4'd0;
   assign outCur = outActive ? outIdx + 4'd1 : 4'd0;
   assign enSeen = madd_en | msub_en | mmul_en | minv_mdiv_en;
   assign opSeen = madd_en ? 3'd0 : msub_en ? 3'd1 : mmul_en ? 3'd2 : (minv_mdiv ? 3'd4 : 3'd3);
   assign madd_msub_rdy = mRdy && (mGrp == 2'd0);
   assign mmul_rdy      = mRdy && (mGrp == 2'd1);
   assign minv_mdiv_rdy = mRdy && (mGrp == 2'd2);

   // The model keeps ready high until one cycle after the next enable, mimicking a stale flag.
   always @(posedge clk) begin
      ldActive   <= load_en;
      ldAddrPrev <= load_addr;
      outActive  <= out_en;
      if (load_en) begin
         ldIdx <= ldCur;
         case (load_addr)
            4'd0:    mA[{ldCur, 4'b0000} +: 16] <= datain;
            4'd1:    mB[{ldCur, 4'b0000} +: 16] <= datain;
            4'd2:    mP[{ldCur, 4'b0000} +: 16] <= datain;
            default: ;
         endcase
      end
      if (out_en) begin
         outIdx  <= outCur;
         dataout <= mRes[{outCur, 4'b0000} +: 16];
      end
      if (enSeen) begin
         mRes   <= modelCompute(opSeen, mA, mB, mP);
         mGrp   <= madd_en || msub_en ? 2'd0 : mmul_en ? 2'd1 : 2'd2;
         mDrop  <= 1'b1;
         mCd    <= rdyDelay;
         mFresh <= 1'b0;
      end else if (mDrop) begin
         mRdy  <= 1'b0;
         mDrop <= 1'b0;
      end else if (mCd != 0) begin
         mCd <= mCd - 1;
         if (mCd == 1) begin
            mRdy   <= 1'b1;
            mFresh <= 1'b1;
         end
      end
   end

   int loadCycles = 0, addr2Cycles = 0, maddP = 0, msubP = 0, mmulP = 0, minvP = 0;
   int minvSeen = 0, earlyRead = 0, badAddr = 0;

   always @(negedge clk) begin
      if (load_en) loadCycles <= loadCycles + 1;
      if (load_en && load_addr == 4'd2) addr2Cycles <= addr2Cycles + 1;
      if (madd_en) maddP <= maddP + 1;
      if (msub_en) msubP <= msubP + 1;
      if (mmul_en) mmulP <= mmulP + 1;
      if (minv_mdiv_en) minvP <= minvP + 1;
      if (minv_mdiv) minvSeen <= minvSeen + 1;
      if (out_en && !mFresh) earlyRead <= earlyRead + 1;
      if (out_addr != 2'd0) badAddr <= badAddr + 1;
   end

   typedef struct {
      logic [255:0] res;
      logic         err;
   } exp_t;
   exp_t sbQ[$];
   exp_t monE;

   // Scoreboard monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected done: got done=1 expected no done, result %0h", result);
         end else begin
            monE = sbQ.pop_front();
            checkOutput("sb result", result, monE.res);
            checkOutput("sb err", 256'(err), 256'(monE.err));
            checkOutput("sb busy at done", 256'(busy), 256'd0);
         end
      end
   end

   task automatic applyStimulus(input logic [2:0] o, input logic lp, input logic [255:0] a,
                                input logic [255:0] b, input logic [255:0] p,
                                input logic [255:0] expRes, input logic expErr, input int delay);
      @(posedge clk);
      #1;
      loadCycles = 0; addr2Cycles = 0; maddP = 0; msubP = 0; mmulP = 0; minvP = 0;
      minvSeen = 0; earlyRead = 0;
      rdyDelay = delay;
      op = o; load_p = lp; a_in = a; b_in = b; p_in = p;
      start = 1'b1;
      startCyc = cyc;
      sbQ.push_back('{res: expRes, err: expErr});
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input string name, output int lat);
      int n;
      n = 0;
      lat = -1;
      while (n < 400) begin
         @(negedge clk);
         if (done) begin
            lat = cyc - startCyc + 1;
            break;
         end
         n++;
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s timeout: got no done within 400 cycles expected done", name);
      end
   endtask

   logic [31:0] outVec;
   assign outVec = {busy, done, err, load_en, madd_en, msub_en, mmul_en, minv_mdiv, minv_mdiv_en,
                    out_en, load_addr, datain, out_addr};

   int lat;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset outputs", 256'(outVec), 256'd0);
      checkOutput("reset result", result, 256'd0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(3'd0, 1'b1, 256'd5, 256'd7, 256'd11, 256'd1, 1'b0, 3);
      waitDone("madd", lat);
      checkOutput("madd latency", 256'(lat), 256'd73);
      checkOutput("madd load cycles", 256'(loadCycles), 256'd48);
      checkOutput("madd p cycles", 256'(addr2Cycles), 256'd16);
      checkOutput("madd_en pulses", 256'(maddP), 256'd1);
      checkOutput("madd early read", 256'(earlyRead), 256'd0);

      applyStimulus(3'd1, 1'b0, 256'd5, 256'd7, 256'd11, 256'd9, 1'b0, 3);
      repeat (10) @(posedge clk);
      #1;
      op = 3'd0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone("msub", lat);
      checkOutput("msub latency", 256'(lat), 256'd57);
      checkOutput("msub load cycles", 256'(loadCycles), 256'd32);
      checkOutput("msub p cycles", 256'(addr2Cycles), 256'd0);
      checkOutput("msub_en pulses", 256'(msubP), 256'd1);

      applyStimulus(3'd2, 1'b1, 256'd5, 256'd7, 256'd11, 256'd2, 1'b0, 2);
      waitDone("mmul", lat);
      checkOutput("mmul latency", 256'(lat), 256'd72);
      checkOutput("mmul_en pulses", 256'(mmulP), 256'd1);
      applyStimulus(3'd3, 1'b0, 256'd5, 256'd7, 256'd11, 256'd9, 1'b0, 2);
      waitDone("minv", lat);
      checkOutput("minv back-to-back latency", 256'(lat), 256'd56);
      checkOutput("minv_mdiv level", 256'(minvSeen), 256'd0);
      checkOutput("minv_mdiv_en pulses", 256'(minvP), 256'd1);

      applyStimulus(3'd6, 1'b1, 256'd1, 256'd2, 256'd11, 256'd9, 1'b1, 3);
      waitDone("illegal op", lat);
      checkOutput("illegal latency", 256'(lat), 256'd2);
      checkOutput("illegal load cycles", 256'(loadCycles), 256'd0);
      checkOutput("illegal enables", 256'(maddP + msubP + mmulP + minvP), 256'd0);
      repeat (3) @(negedge clk);
      checkOutput("err held", 256'(err), 256'd1);
      checkOutput("result held", result, 256'd9);

      applyStimulus(3'd3, 1'b1, 256'd3, 256'd7, 256'd11, 256'd4, 1'b0, STUCK_DELAY);
      waitDone("stale ready", lat);
      checkOutput("stale ready latency", 256'(lat), 256'(70 + STUCK_DELAY));
      checkOutput("stale ready early read", 256'(earlyRead), 256'd0);

      applyStimulus(3'd0, 1'b1, 256'd5, 256'hBEEF << 112, 256'd11, 256'd0, 1'b0, 3);
      repeat (24) @(negedge clk);
      checkOutput("b word7 addr", 256'(load_addr), 256'd1);
      checkOutput("b word7 data", 256'(datain), 256'hBEEF);
      rst_n = 1'b0;
      sbQ.delete();
      #1;
      checkOutput("async reset outputs", 256'(outVec), 256'd0);
      checkOutput("async reset result", result, 256'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(3'd0, 1'b1, 256'd5, 256'd7, 256'd11, 256'd1, 1'b0, 3);
      waitDone("madd after reset", lat);
      checkOutput("madd after reset latency", 256'(lat), 256'd73);

`ifdef PFSEQ_TIMEOUT_EN
      applyStimulus(3'd0, 1'b0, 256'd5, 256'd7, 256'd11, 256'd1, 1'b1, 100);
      waitDone("timeout", lat);
      checkOutput("timeout latency", 256'(lat), 256'd52);
`endif

      checkOutput("out_addr never set", 256'(badAddr), 256'd0);
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
